bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have one parameter, HOLD_MAX, default 16: the maximum number of consecutive grant cycles allowed while another master requests; legal range 2..255.
REQ-002 The module SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  input  1  bus clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 m0_req_ .. m3_req_  input  1 each  bus request from master n; active-low (`ENABLE_ = request).
REQ-006 m0_grnt_ .. m3_grnt_  output  1 each  bus grant to master n; active-low; driven from registers; feeds bus_master_mux directly.
REQ-007 owner  output  2  index of the current or last granted master.
REQ-008 bus_busy  output  1  active-high; asserted while any grant is asserted.
REQ-009 preempt  output  1  active-high, one-cycle pulse; asserted in the cycle a grant is revoked by the hold limit.

Function
REQ-010 At most one grnt_ SHALL be at `ENABLE_ in any cycle; all four at `DISABLE_ is legal only in IDLE.
REQ-011 The FSM SHALL have exactly two states: IDLE (no grant) and GRANT (grant to owner).
REQ-012 IDLE -> GRANT: when any req_ is `ENABLE_ at a clock edge, the grant to the selected master SHALL appear after that edge (latency 1 cycle).
REQ-013 Selection SHALL be round-robin: search order owner+1, owner+2, owner+3, owner (mod 4); the first requesting master in that order is selected.
REQ-014 In GRANT, while the owner's req_ stays `ENABLE_ and no other master requests, the grant SHALL be held indefinitely; hold_cnt SHALL saturate at HOLD_MAX.
REQ-015 In GRANT, when the owner's req_ is `DISABLE_ and another master requests, the grant SHALL pass to the round-robin winner on the next edge, with no idle cycle.
REQ-016 In GRANT, when the owner's req_ is `DISABLE_ and no master requests, the FSM SHALL go to IDLE with all grants `DISABLE_; owner SHALL keep its value.
REQ-017 hold_cnt (8 bits) SHALL load 1 on every new grant and increment each GRANT cycle.
REQ-018 When hold_cnt = HOLD_MAX, the owner still requests, and another master requests, the grant SHALL move to the round-robin winner excluding the owner, and preempt SHALL pulse for that cycle.
REQ-019 A master whose grant was revoked SHALL be reconsidered only through normal round-robin order.
REQ-020 Simultaneous requests from IDLE SHALL be resolved only by REQ-013; there SHALL be no fixed priority.
REQ-021 Request changes SHALL affect grants only at clock edges; there SHALL be no combinational path from req_ to grnt_.

Reset
REQ-022 While reset is high: state = IDLE, all grnt_ = `DISABLE_, owner = 0, hold_cnt = 0, bus_busy = 0, preempt = 0.
REQ-023 Reset asserted during GRANT SHALL drop the grant immediately (asynchronously), with no completion of the transfer.
REQ-024 After reset deasserts, the first arbitration SHALL search from master 1, since owner = 0.

Structure
REQ-025 bus.h SHALL hold BUS_MASTER_CH (4), BUS_OWNER_W (2), BUS_OWNER_MASTER_0..3 encodings, BUS_HOLD_MAX_DEFAULT (16), and the state encodings BUS_ARB_IDLE and BUS_ARB_GRANT.
REQ-026 The round-robin search SHALL be a combinational sub-module, bus_rr_pick, instantiated once.
    - Inputs: request vector, start index, exclude-owner flag.
    - Outputs: winner index, any-valid flag.

Verification
REQ-027 Reset, then m2_req_ low at cycle 0 -> m2_grnt_ low from cycle 1, owner = 2, bus_busy = 1.
REQ-028 owner = 0, all four req_ low at the same edge -> m1_grnt_ low the next cycle; then m1 releases -> m2, then m3, then m0, with no idle cycles between grants.
REQ-029 HOLD_MAX = 4, m0 holds req_ and m3 requests -> m0 granted 4 cycles, then m3_grnt_ low and preempt = 1 for exactly one cycle.
REQ-030 m1 alone holds req_ for 300 cycles -> grant held throughout, preempt never asserted.
REQ-031 m2 granted, reset pulsed for 1 cycle mid-grant -> all grnt_ high immediately, owner = 0; m2 still requesting -> m2_grnt_ low one cycle after reset deasserts.
REQ-032 Every cycle of every test -> assertion that at most one grnt_ is low.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the four-master bus arbiter: widths, owner and state
// encodings, grant polarity, and a helper that builds an active-low grant vector.
package bus_arbiter_pkg;

  localparam int unsigned BUS_MASTER_CH        = 4;
  localparam int unsigned BUS_OWNER_W          = 2;
  localparam int unsigned BUS_HOLD_W           = 8;
  localparam int unsigned BUS_HOLD_MAX_DEFAULT = 16;

  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic [0:0] BUS_ARB_IDLE  = 1'b0;
  localparam logic [0:0] BUS_ARB_GRANT = 1'b1;

  // Request/grant strobes are active-low on the bus.
  localparam logic BUS_ENABLE  = 1'b0;
  localparam logic BUS_DISABLE = 1'b1;

  localparam logic [BUS_MASTER_CH-1:0] BUS_GRANT_NONE = {BUS_MASTER_CH{BUS_DISABLE}};

  function automatic logic [BUS_MASTER_CH-1:0] grant_vec(input logic [BUS_OWNER_W-1:0] idx);
    logic [BUS_MASTER_CH-1:0] one_hot;
    one_hot = BUS_MASTER_CH'(1) << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin search: first active request starting at 'start',
// optionally skipping the last slot in the order (the current owner).
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  logic [BUS_OWNER_W-1:0]   start,
  input  logic                     excl,
  output logic [BUS_OWNER_W-1:0]   winner,
  output logic                     valid
);

  logic [BUS_OWNER_W-1:0] idx;

  always_comb begin
    winner = start;
    valid  = 1'b0;
    idx    = start;
    for (int i = 0; i < int'(BUS_MASTER_CH); i++) begin
      idx = start + BUS_OWNER_W'(i);
      if (!valid && req[idx] && !(excl && (i == int'(BUS_MASTER_CH) - 1))) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered active-low grants and a
// hold limit that preempts a long-running owner when others are waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = BUS_HOLD_MAX_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_,
  input  logic                   m1_req_,
  input  logic                   m2_req_,
  input  logic                   m3_req_,
  output logic                   m0_grnt_,
  output logic                   m1_grnt_,
  output logic                   m2_grnt_,
  output logic                   m3_grnt_,
  output logic [BUS_OWNER_W-1:0] owner,
  output logic                   bus_busy,
  output logic                   preempt
);

  localparam logic [BUS_HOLD_W-1:0] HOLD_LIMIT = BUS_HOLD_W'(HOLD_MAX);

  logic [0:0]               state, state_nxt;
  logic [BUS_OWNER_W-1:0]   owner_nxt;
  logic [BUS_HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [BUS_MASTER_CH-1:0] grnt, grnt_nxt;
  logic                     busy_nxt, preempt_nxt;

  logic [BUS_MASTER_CH-1:0] req;
  logic                     own_req;
  logic                     pick_excl;
  logic [BUS_OWNER_W-1:0]   pick_idx;
  logic                     pick_valid;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign own_req   = req[owner];
  // While the owner still requests, only other masters can win the search.
  assign pick_excl = (state == BUS_ARB_GRANT) && own_req;

  bus_rr_pick u_rr_pick (
    .req    (req),
    .start  (owner + BUS_OWNER_W'(1)),
    .excl   (pick_excl),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    hold_nxt    = hold_cnt;
    grnt_nxt    = grnt;
    preempt_nxt = 1'b0;
    case (state)
      BUS_ARB_IDLE: begin
        grnt_nxt = BUS_GRANT_NONE;
        hold_nxt = '0;
        if (pick_valid) begin
          state_nxt = BUS_ARB_GRANT;
          owner_nxt = pick_idx;
          hold_nxt  = BUS_HOLD_W'(1);
          grnt_nxt  = grant_vec(pick_idx);
        end
      end
      BUS_ARB_GRANT: begin
        if (own_req) begin
          if (pick_valid && (hold_cnt >= HOLD_LIMIT)) begin
            owner_nxt   = pick_idx;
            hold_nxt    = BUS_HOLD_W'(1);
            grnt_nxt    = grant_vec(pick_idx);
            preempt_nxt = 1'b1;
          end else if (hold_cnt < HOLD_LIMIT) begin
            hold_nxt = hold_cnt + BUS_HOLD_W'(1);
          end
        end else if (pick_valid) begin
          owner_nxt = pick_idx;
          hold_nxt  = BUS_HOLD_W'(1);
          grnt_nxt  = grant_vec(pick_idx);
        end else begin
          state_nxt = BUS_ARB_IDLE;
          hold_nxt  = '0;
          grnt_nxt  = BUS_GRANT_NONE;
        end
      end
      default: begin
        state_nxt = BUS_ARB_IDLE;
        hold_nxt  = '0;
        grnt_nxt  = BUS_GRANT_NONE;
      end
    endcase
    busy_nxt = (state_nxt == BUS_ARB_GRANT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BUS_ARB_IDLE;
      owner    <= BUS_OWNER_MASTER_0;
      hold_cnt <= '0;
      grnt     <= BUS_GRANT_NONE;
      bus_busy <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      grnt     <= grnt_nxt;
      bus_busy <= busy_nxt;
      preempt  <= preempt_nxt;
    end
  end

  assign m0_grnt_ = grnt[0];
  assign m1_grnt_ = grnt[1];
  assign m2_grnt_ = grnt[2];
  assign m3_grnt_ = grnt[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (HOLD_MAX = 4).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       bus_busy, preempt;
  logic [3:0] grnt_n;

  int checks = 0;
  int passed = 0;

  assign grnt_n = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (req_n[0]),
    .m1_req_  (req_n[1]),
    .m2_req_  (req_n[2]),
    .m3_req_  (req_n[3]),
    .m0_grnt_ (m0_grnt_),
    .m1_grnt_ (m1_grnt_),
    .m2_grnt_ (m2_grnt_),
    .m3_grnt_ (m3_grnt_),
    .owner    (owner),
    .bus_busy (bus_busy),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  // At most one grant low in every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones(~grnt_n) > 1)
      $display("FAIL onehot grants=%b required at most one low", grnt_n);
    else
      passed++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_n = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_n = 4'b0000;
    tick();
    checks++;
    if (grnt_n !== 4'b1111) $display("FAIL reset_grnt got %b exp 1111", grnt_n); else passed++;
    checks++;
    if (owner !== 2'd0) $display("FAIL reset_owner got %0d exp 0", owner); else passed++;
    checks++;
    if (bus_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus_busy); else passed++;
    checks++;
    if (preempt !== 1'b0) $display("FAIL reset_preempt got %b exp 0", preempt); else passed++;
    req_n = 4'b1111;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_request();
    apply_reset();
    req_n = 4'b1011;
    #1;
    checks++;
    if (grnt_n !== 4'b1111) $display("FAIL single_no_comb got %b exp 1111", grnt_n); else passed++;
    tick();
    checks++;
    if (grnt_n !== 4'b1011) $display("FAIL single_grnt got %b exp 1011", grnt_n); else passed++;
    checks++;
    if (owner !== 2'd2) $display("FAIL single_owner got %0d exp 2", owner); else passed++;
    checks++;
    if (bus_busy !== 1'b1) $display("FAIL single_busy got %b exp 1", bus_busy); else passed++;
    req_n = 4'b1111;
    tick();
    checks++;
    if (grnt_n !== 4'b1111) $display("FAIL idle_grnt got %b exp 1111", grnt_n); else passed++;
    checks++;
    if (owner !== 2'd2) $display("FAIL idle_owner got %0d exp 2", owner); else passed++;
    checks++;
    if (bus_busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", bus_busy); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_req [4];
    logic [3:0] rr_exp [4];
    logic [1:0] rr_own [4];
    rr_req = '{4'b0000, 4'b0010, 4'b0110, 4'b1110};
    rr_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rr_own = '{2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      req_n = rr_req[k];
      tick();
      checks++;
      if (grnt_n !== rr_exp[k]) $display("FAIL rr_grnt step %0d got %b exp %b", k, grnt_n, rr_exp[k]); else passed++;
      checks++;
      if (owner !== rr_own[k]) $display("FAIL rr_owner step %0d got %0d exp %0d", k, owner, rr_own[k]); else passed++;
      checks++;
      if (bus_busy !== 1'b1) $display("FAIL rr_busy step %0d got %b exp 1", k, bus_busy); else passed++;
    end
    req_n = 4'b1111;
    tick();
    checks++;
    if (grnt_n !== 4'b1111) $display("FAIL rr_release got %b exp 1111", grnt_n); else passed++;
  endtask

  task automatic test_preempt();
    apply_reset();
    req_n = 4'b1110;
    tick();
    req_n = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grnt_n !== 4'b1110 || preempt !== 1'b0)
        $display("FAIL hold_m0 cycle %0d got grnt=%b preempt=%b exp grnt=1110 preempt=0", k, grnt_n, preempt);
      else
        passed++;
      tick();
    end
    checks++;
    if (grnt_n !== 4'b0111) $display("FAIL preempt_grnt got %b exp 0111", grnt_n); else passed++;
    checks++;
    if (preempt !== 1'b1) $display("FAIL preempt_pulse got %b exp 1", preempt); else passed++;
    checks++;
    if (owner !== 2'd3) $display("FAIL preempt_owner got %0d exp 3", owner); else passed++;
    tick();
    checks++;
    if (preempt !== 1'b0) $display("FAIL preempt_width got %b exp 0", preempt); else passed++;
    checks++;
    if (grnt_n !== 4'b0111) $display("FAIL preempt_keep got %b exp 0111", grnt_n); else passed++;
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_long_hold();
    int bad;
    bad = 0;
    apply_reset();
    req_n = 4'b1101;
    tick();
    repeat (300) begin
      if (grnt_n !== 4'b1101 || preempt !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) $display("FAIL long_hold bad_cycles got %0d exp 0", bad); else passed++;
    req_n = 4'b1111;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req_n = 4'b1011;
    tick();
    checks++;
    if (grnt_n !== 4'b1011) $display("FAIL mid_pre_grnt got %b exp 1011", grnt_n); else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grnt_n !== 4'b1111) $display("FAIL mid_async_grnt got %b exp 1111", grnt_n); else passed++;
    checks++;
    if (owner !== 2'd0) $display("FAIL mid_async_owner got %0d exp 0", owner); else passed++;
    checks++;
    if (bus_busy !== 1'b0) $display("FAIL mid_async_busy got %b exp 0", bus_busy); else passed++;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (grnt_n !== 4'b1111) $display("FAIL mid_release_grnt got %b exp 1111", grnt_n); else passed++;
    tick();
    checks++;
    if (grnt_n !== 4'b1011) $display("FAIL mid_regrant got %b exp 1011", grnt_n); else passed++;
    checks++;
    if (owner !== 2'd2) $display("FAIL mid_regrant_owner got %0d exp 2", owner); else passed++;
    req_n = 4'b1111;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req_n = 4'b1111;
    test_reset();
    test_single_request();
    test_round_robin();
    test_preempt();
    test_long_hold();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
